// File: rtl/spi_ram_pkg.sv
//------------------------------------------------------------------------------
// spi_ram_pkg : opcodes, FSM states and mode constants for spi_ram_responder
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_ram_pkg;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WRSR  = 8'h01;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        RD     = 3'd3,
        WR     = 3'd4,
        IGNORE = 3'd5
    } state_t;
endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
//------------------------------------------------------------------------------
// spi_sync_edge : 2-flop synchronizer with registered rise/fall pulses
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_rise;
    logic r_fall;

    // Edge pulses are computed from the metastable stage so they line up with r_sync.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_rise <= r_meta & ~r_sync;
            r_fall <= ~r_meta & r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

`default_nettype wire

// File: rtl/spi_ram_responder.sv
//------------------------------------------------------------------------------
// spi_ram_responder : 23LC-style SPI SRAM slave with backdoor preload port.
// Optional SPI_RAM_STATUS_EN adds the RDSR/WRSR mode register. Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_ram_responder
    import spi_ram_pkg::*;
#(
    parameter int ADDR_BITS     = 16,
    parameter int MEM_ADDR_BITS = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_spi_clk,
    input  logic                     i_spi_select,
    input  logic                     i_spi_mosi,
    output logic                     o_spi_miso,
    input  logic                     i_bd_we,
    input  logic [MEM_ADDR_BITS-1:0] i_bd_addr,
    input  logic [7:0]               i_bd_wdata,
    output logic [7:0]               o_bd_rdata,
    output logic                     o_bd_ack,
    output logic                     o_active
);
    localparam int CW    = $clog2(ADDR_BITS + 1);
    localparam int SW    = (MEM_ADDR_BITS > 8) ? MEM_ADDR_BITS : 8;
    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    logic [7:0]               r_mem [DEPTH];
    state_t                   r_state;
    logic [CW-1:0]            r_bitcnt;
    logic [SW-2:0]            r_shift;
    logic [MEM_ADDR_BITS-1:0] r_ptr;
    logic [7:0]               r_out;
    logic                     r_miso;
    logic                     r_active;
    logic                     r_is_read;
    logic [7:0]               r_bd_rdata;
    logic                     r_bd_ack;
    logic                     r_sel_meta, r_sel_sync;
    logic                     r_mosi_meta, r_mosi_sync;
`ifdef SPI_RAM_STATUS_EN
    logic [7:0]               r_mode;
    logic                     r_sr;
`endif

    logic                     w_sck_sync, w_sck_rise, w_sck_fall;
    logic [SW-1:0]            w_shift_next;
    logic [7:0]               w_byte_in;
    logic [MEM_ADDR_BITS-1:0] w_addr;
    logic [MEM_ADDR_BITS-1:0] w_ptr_inc;
    logic                     w_last8;
    logic                     w_byte_mode;
    logic                     w_spi_we;

    spi_sync_edge u_sck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_async(i_spi_clk),
        .o_sync (w_sck_sync),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_meta  <= 1'b1;
            r_sel_sync  <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sel_meta  <= i_spi_select;
            r_sel_sync  <= r_sel_meta;
            r_mosi_meta <= i_spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_shift_next = {r_shift, r_mosi_sync};
    assign w_byte_in    = w_shift_next[7:0];
    assign w_addr       = w_shift_next[MEM_ADDR_BITS-1:0];
    assign w_ptr_inc    = r_ptr + MEM_ADDR_BITS'(1);
    assign w_last8      = (r_bitcnt == CW'(7));
`ifdef SPI_RAM_STATUS_EN
    assign w_byte_mode  = (r_mode[7:6] == MODE_BYTE);
    assign w_spi_we     = (r_state == WR) && !r_sel_sync && w_sck_rise && w_last8 && !r_sr;
`else
    assign w_byte_mode  = 1'b0;
    assign w_spi_we     = (r_state == WR) && !r_sel_sync && w_sck_rise && w_last8;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_out     <= '0;
            r_miso    <= 1'b0;
            r_active  <= 1'b0;
            r_is_read <= 1'b0;
`ifdef SPI_RAM_STATUS_EN
            r_mode    <= {MODE_SEQ, 6'b0};
            r_sr      <= 1'b0;
`endif
        end else begin
            r_active <= ~r_sel_sync;
            if (r_sel_sync) begin
                r_state  <= IDLE;
                r_bitcnt <= '0;
                r_miso   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_miso <= 1'b0;
                        // Only start on an idle-low SCK so a late select cannot split a bit.
                        if (!w_sck_sync) begin
                            r_bitcnt <= '0;
                            r_state  <= CMD;
`ifdef SPI_RAM_STATUS_EN
                            r_sr     <= 1'b0;
`endif
                        end
                    end
                    CMD: if (w_sck_rise) begin
                        r_shift  <= w_shift_next[SW-2:0];
                        r_bitcnt <= r_bitcnt + CW'(1);
                        if (w_last8) begin
                            r_bitcnt <= '0;
                            case (w_byte_in)
                                OP_READ:  begin r_is_read <= 1'b1; r_state <= ADDR; end
                                OP_WRITE: begin r_is_read <= 1'b0; r_state <= ADDR; end
`ifdef SPI_RAM_STATUS_EN
                                OP_RDSR:  begin r_sr <= 1'b1; r_out <= r_mode; r_state <= RD; end
                                OP_WRSR:  begin r_sr <= 1'b1; r_state <= WR; end
`endif
                                default:  r_state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: if (w_sck_rise) begin
                        r_shift  <= w_shift_next[SW-2:0];
                        r_bitcnt <= r_bitcnt + CW'(1);
                        if (r_bitcnt == CW'(ADDR_BITS - 1)) begin
                            r_bitcnt <= '0;
                            r_ptr    <= w_addr;
                            r_out    <= r_mem[w_addr];
                            r_state  <= r_is_read ? RD : WR;
                        end
                    end
                    RD: begin
                        if (w_sck_fall) begin
                            r_miso <= r_out[7];
                            r_out  <= {r_out[6:0], 1'b0};
                        end else if (w_sck_rise) begin
                            r_bitcnt <= r_bitcnt + CW'(1);
                            if (w_last8) begin
                                r_bitcnt <= '0;
                                r_ptr    <= w_ptr_inc;
`ifdef SPI_RAM_STATUS_EN
                                r_out    <= r_sr ? r_mode : r_mem[w_ptr_inc];
                                if (w_byte_mode && !r_sr)
                                    r_state <= IGNORE;
`else
                                r_out    <= r_mem[w_ptr_inc];
                                if (w_byte_mode)
                                    r_state <= IGNORE;
`endif
                            end
                        end
                    end
                    WR: if (w_sck_rise) begin
                        r_shift  <= w_shift_next[SW-2:0];
                        r_bitcnt <= r_bitcnt + CW'(1);
                        if (w_last8) begin
                            r_bitcnt <= '0;
                            r_ptr    <= w_ptr_inc;
`ifdef SPI_RAM_STATUS_EN
                            if (r_sr) begin
                                r_mode  <= w_byte_in;
                                r_state <= IGNORE;
                            end else if (w_byte_mode) begin
                                r_state <= IGNORE;
                            end
`else
                            if (w_byte_mode)
                                r_state <= IGNORE;
`endif
                        end
                    end
                    IGNORE:  r_miso <= 1'b0;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // SPI commits only happen while active, so they never collide with an accepted backdoor write.
    always_ff @(posedge clk) begin
        if (w_spi_we)
            r_mem[r_ptr] <= w_byte_in;
        else if (i_bd_we && !r_active)
            r_mem[i_bd_addr] <= i_bd_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bd_rdata <= '0;
            r_bd_ack   <= 1'b0;
        end else begin
            r_bd_rdata <= r_mem[i_bd_addr];
            r_bd_ack   <= i_bd_we & ~r_active;
        end
    end

    assign o_spi_miso = r_miso;
    assign o_bd_rdata = r_bd_rdata;
    assign o_bd_ack   = r_bd_ack;
    assign o_active   = r_active;
endmodule

`default_nettype wire
